// File: rtl/matrix_pkg.sv
// Shared types and defaults for the matrix stream loader and its multiplier.
// Holds the loader state enum, index-width helper and default dimensions.
package matrix_pkg;

    localparam int DEFAULT_MATRIX_SIZE = 3;
    localparam int DEFAULT_WORD_LENGTH = 8;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    // Row/col counters need at least one bit even for N=1.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_idx_counter.sv
// Row-major (row, col) index counter over an N x N matrix.
// Ports: clk, rst_n, clear, advance in; row, col, at_last out.
module mat_idx_counter
    import matrix_pkg::*;
#(
    parameter int N = DEFAULT_MATRIX_SIZE,
    localparam int IDX_W = idx_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             at_last
);

    // Wrap point is N-1, not the counter's power-of-two limit.
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    logic [IDX_W-1:0] row_q;
    logic [IDX_W-1:0] row_d;
    logic [IDX_W-1:0] col_q;
    logic [IDX_W-1:0] col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (col_q == LAST) begin
                col_d = '0;
                if (row_q == LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row     = row_q;
    assign col     = col_q;
    assign at_last = (row_q == LAST) && (col_q == LAST);

endmodule

// File: rtl/matrix_stream_loader.sv
// Stream loader/drainer around a combinational N x N matrix multiplier.
// Ports: in_* word stream in, A_out/B_out/C_in to multiplier, out_* stream.
module matrix_stream_loader
    import matrix_pkg::*;
#(
    parameter int MATRIX_SIZE = DEFAULT_MATRIX_SIZE,
    parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH,
    localparam int N = MATRIX_SIZE,
    localparam int W = WORD_LENGTH,
    localparam int IDX_W = idx_width(MATRIX_SIZE)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic [W-1:0] A_out [0:N-1][0:N-1],
    output logic [W-1:0] B_out [0:N-1][0:N-1],
    input  logic [W-1:0] C_in  [0:N-1][0:N-1],
    output logic         mats_valid,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last
);

    state_e state_q;
    state_e state_d;

    logic in_ready_q;
    logic in_ready_d;
    logic mats_valid_q;
    logic mats_valid_d;
    logic out_valid_q;
    logic out_valid_d;

    logic [W-1:0] a_q [0:N-1][0:N-1];
    logic [W-1:0] a_d [0:N-1][0:N-1];
    logic [W-1:0] b_q [0:N-1][0:N-1];
    logic [W-1:0] b_d [0:N-1][0:N-1];
    logic [W-1:0] c_q [0:N-1][0:N-1];
    logic [W-1:0] c_d [0:N-1][0:N-1];

    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic             at_last;
    logic             cnt_clear;
    logic             cnt_advance;

    logic in_hs;
    logic out_hs;
    logic a_wr;
    logic b_wr;
    logic c_cap;

    // One counter serves load indexing and drain indexing; the
    // phases never overlap and each ends with the counter cleared.
    mat_idx_counter #(
        .N (N)
    ) u_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .row     (row),
        .col     (col),
        .at_last (at_last)
    );

    assign in_hs  = in_valid && in_ready_q;
    assign out_hs = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;
        a_wr        = 1'b0;
        b_wr        = 1'b0;
        c_cap       = 1'b0;
        case (state_q)
            LOAD_A: begin
                if (in_hs) begin
                    a_wr = 1'b1;
                    if (at_last) begin
                        cnt_clear = 1'b1;
                        state_d   = LOAD_B;
                    end else begin
                        cnt_advance = 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (in_hs) begin
                    b_wr = 1'b1;
                    if (at_last) begin
                        cnt_clear = 1'b1;
                        state_d   = CAPTURE;
                    end else begin
                        cnt_advance = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                c_cap   = 1'b1;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (out_hs) begin
                    if (at_last) begin
                        cnt_clear = 1'b1;
                        state_d   = LOAD_A;
                    end else begin
                        cnt_advance = 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase

        // Handshake flags are registered from the next state so they
        // never depend combinationally on in_valid or out_ready.
        in_ready_d   = (state_d == LOAD_A) || (state_d == LOAD_B);
        mats_valid_d = (state_d == CAPTURE) || (state_d == DRAIN);
        out_valid_d  = (state_d == DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD_A;
            in_ready_q   <= 1'b0;
            mats_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            mats_valid_q <= mats_valid_d;
            out_valid_q  <= out_valid_d;
        end
    end

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        if (a_wr) begin
            a_d[row][col] = in_data;
        end
        if (b_wr) begin
            b_d[row][col] = in_data;
        end
        if (c_cap) begin
            c_d = C_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '{default: '0};
            b_q <= '{default: '0};
            c_q <= '{default: '0};
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
        end
    end

    // out_data follows the drain index; it is forced to zero outside DRAIN.
    always_comb begin
        out_data = '0;
        if (out_valid_q) begin
            out_data = c_q[row][col];
        end
    end

    assign out_last   = out_valid_q && at_last;
    assign in_ready   = in_ready_q;
    assign mats_valid = mats_valid_q;
    assign out_valid  = out_valid_q;
    assign A_out      = a_q;
    assign B_out      = b_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Randomised self-checking bench for matrix_stream_loader (N=3 and N=1).
// A behavioural multiplier feeds C_in; expectations come from a matrix model.
module tb_matrix_stream_loader;

    localparam int N  = 3;
    localparam int NN = N * N;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] a_out [0:N-1][0:N-1];
    logic [7:0] b_out [0:N-1][0:N-1];
    logic [7:0] c_in  [0:N-1][0:N-1];
    logic       mats_valid;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    logic       in_valid1;
    logic       in_ready1;
    logic [7:0] in_data1;
    logic [7:0] a_out1 [0:0][0:0];
    logic [7:0] b_out1 [0:0][0:0];
    logic [7:0] c_in1  [0:0][0:0];
    logic       mats_valid1;
    logic       out_valid1;
    logic       out_ready1;
    logic [7:0] out_data1;
    logic       out_last1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sa [NN];
    logic [7:0] sb [NN];
    int         exp_c [NN];

    always #5 clk = ~clk;

    matrix_stream_loader #(
        .MATRIX_SIZE (3),
        .WORD_LENGTH (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .A_out      (a_out),
        .B_out      (b_out),
        .C_in       (c_in),
        .mats_valid (mats_valid),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    matrix_stream_loader #(
        .MATRIX_SIZE (1),
        .WORD_LENGTH (8)
    ) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .in_data    (in_data1),
        .A_out      (a_out1),
        .B_out      (b_out1),
        .C_in       (c_in1),
        .mats_valid (mats_valid1),
        .out_valid  (out_valid1),
        .out_ready  (out_ready1),
        .out_data   (out_data1),
        .out_last   (out_last1)
    );

    // Stand-in for the combinational multiplier (8-bit wraparound).
    always_comb begin
        c_in = '{default: '0};
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                c_in[i][j] = a_out[i][0] * b_out[0][j]
                           + a_out[i][1] * b_out[1][j]
                           + a_out[i][2] * b_out[2][j];
            end
        end
    end

    assign c_in1[0][0] = a_out1[0][0] * b_out1[0][0];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic build_expected();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < N; k++) begin
                    s += int'(sa[i*N+k]) * int'(sb[k*N+j]);
                end
                exp_c[i*N+j] = s % 256;
            end
        end
    endtask

    task automatic set_identity_seq();
        for (int i = 0; i < NN; i++) begin
            sa[i] = ((i / N) == (i % N)) ? 8'd1 : 8'd0;
            sb[i] = 8'(i + 1);
        end
    endtask

    task automatic set_const(input logic [7:0] v);
        for (int i = 0; i < NN; i++) begin
            sa[i] = v;
            sb[i] = v;
        end
    endtask

    task automatic set_random();
        for (int i = 0; i < NN; i++) begin
            sa[i] = 8'($urandom);
            sb[i] = 8'($urandom);
        end
    endtask

    // bp_mode: 0 ready always, 1 pattern 1,0,0,1, 2 random.
    task automatic run_txn(input int bp_mode, input bit ff_mode);
        int  k;
        int  n;
        int  guard;
        int  cyc;
        bit  rdy;
        bit  hs;
        build_expected();
        k = 0;
        guard = 0;
        while (k < 2 * NN && guard < 200) begin
            in_valid = 1'b1;
            in_data  = (k < NN) ? sa[k] : sb[k-NN];
            rdy = in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (rdy) k++;
        end
        check("load_count", k, 2 * NN);
        in_valid = ff_mode;
        in_data  = 8'hFF;
        check("capture_mats_valid", int'(mats_valid), 1);
        check("capture_out_valid", int'(out_valid), 0);
        check("capture_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        check("first_out_valid", int'(out_valid), 1);
        n = 0;
        guard = 0;
        cyc = 0;
        while (n < NN && guard < 200) begin
            case (bp_mode)
                0: out_ready = 1'b1;
                1: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid) begin
                check("out_data", int'(out_data), exp_c[n]);
                check("out_last", int'(out_last), (n == NN - 1) ? 1 : 0);
                check("drain_mats_valid", int'(mats_valid), 1);
                check("drain_in_ready", int'(in_ready), 0);
            end
            hs = out_valid && out_ready;
            @(posedge clk);
            #1;
            guard++;
            cyc++;
            if (hs) n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("drain_count", n, NN);
        check("post_in_ready", int'(in_ready), 1);
        check("post_out_valid", int'(out_valid), 0);
        check("post_mats_valid", int'(mats_valid), 0);
        check("post_out_data", int'(out_data), 0);
        for (int i = 0; i < NN; i++) begin
            check("a_hold", int'(a_out[i/N][i%N]), int'(sa[i]));
            check("b_hold", int'(b_out[i/N][i%N]), int'(sb[i]));
        end
    endtask

    initial begin
        int k;
        int guard;
        bit rdy;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        in_data1   = 8'd0;
        out_ready1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_mats_valid", int'(mats_valid), 0);
        check("rst_a22", int'(a_out[2][2]), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);

        set_identity_seq();
        run_txn(0, 1'b0);

        set_const(8'd2);
        run_txn(1, 1'b0);

        set_const(8'd16);
        run_txn(0, 1'b0);

        set_random();
        run_txn(2, 1'b1);
        set_identity_seq();
        run_txn(0, 1'b0);

        // Partial load interrupted by reset.
        sa[0] = 8'h5A;
        sa[1] = 8'hA5;
        k = 0;
        guard = 0;
        while (k < 5 && guard < 50) begin
            in_valid = 1'b1;
            in_data  = 8'h5A + 8'(k);
            rdy = in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (rdy) k++;
        end
        check("partial_count", k, 5);
        in_valid = 1'b0;
        check("partial_a00", int'(a_out[0][0]), 'h5A);
        rst_n = 1'b0;
        #1;
        check("mid_rst_a00", int'(a_out[0][0]), 0);
        check("mid_rst_a11", int'(a_out[1][1]), 0);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_mats_valid", int'(mats_valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_out_data", int'(out_data), 0);
        check("mid_rst_out_last", int'(out_last), 0);
        set_identity_seq();
        run_txn(0, 1'b0);

        repeat (4) begin
            set_random();
            run_txn(2, 1'($urandom_range(0, 1)));
        end

        // N=1 instance.
        guard = 0;
        while (!in_ready1 && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("n1_ready", int'(in_ready1), 1);
        in_valid1 = 1'b1;
        in_data1  = 8'd7;
        @(posedge clk);
        #1;
        check("n1_ready_b", int'(in_ready1), 1);
        in_data1 = 8'd3;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        check("n1_capture_mv", int'(mats_valid1), 1);
        check("n1_capture_ov", int'(out_valid1), 0);
        check("n1_a", int'(a_out1[0][0]), 7);
        check("n1_b", int'(b_out1[0][0]), 3);
        @(posedge clk);
        #1;
        check("n1_out_valid", int'(out_valid1), 1);
        check("n1_out_data", int'(out_data1), 21);
        check("n1_out_last", int'(out_last1), 1);
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        out_ready1 = 1'b0;
        check("n1_post_ready", int'(in_ready1), 1);
        check("n1_post_valid", int'(out_valid1), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
